// File: rtl/sequence_blinker.sv
// sequence_blinker: plays back the stored Simon Says color sequence on one-hot LEDs
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   on_blinker   : playback request, held high by the controller
//   level        : sequence length, sampled only when playback starts
//   mem_data     : color index, valid one cycle after mem_addr
//   mem_addr     : registered pattern-memory read address
//   led          : registered one-hot LED drive, zero when dark
//   blinker_done : registered completion flag, high while finished
//   Define BLINKER_LEAD_IN_EN to insert a dark lead-in pause of OFF_CYCLES before the first flash.
module sequence_blinker #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int MAX_LEVEL  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_blinker,
  input  logic [3:0] level,
  input  logic [1:0] mem_data,
  output logic [3:0] mem_addr,
  output logic [3:0] led,
  output logic       blinker_done
);
  localparam int TW = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [3:0] MAX_LEN = 4'(MAX_LEVEL);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHOW  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
`ifdef BLINKER_LEAD_IN_EN
  localparam logic [2:0] LEAD  = 3'd6;
  localparam logic [2:0] FIRST = LEAD;
`else
  localparam logic [2:0] FIRST = FETCH;
`endif
  logic [2:0]    state;
  logic [3:0]    idx, len, clamped, idx_next;
  logic [TW-1:0] timer;
  assign clamped  = level > MAX_LEN ? MAX_LEN : level;
  assign idx_next = idx + 4'd1;
  // The read address is the step index register itself, so it is registered and never wraps.
  assign mem_addr = idx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      len          <= '0;
      timer        <= '0;
      led          <= '0;
      blinker_done <= 1'b0;
    end else if (!on_blinker && state != IDLE && state != DONE) begin
      // Abort: drop everything, no done pulse.
      state        <= IDLE;
      led          <= '0;
      blinker_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (on_blinker) begin
          len   <= clamped;
          idx   <= '0;
          timer <= OFF_LOAD;
          state <= clamped == 4'd0 ? DONE : FIRST;
        end
`ifdef BLINKER_LEAD_IN_EN
        LEAD: if (timer == '0) state <= FETCH;
              else timer <= timer - TW'(1);
`endif
        FETCH: state <= LOAD;
        LOAD: begin
          led   <= 4'b0001 << mem_data;
          timer <= ON_LOAD;
          state <= SHOW;
        end
        SHOW: if (timer == '0) begin
          led   <= '0;
          timer <= OFF_LOAD;
          state <= GAP;
        end else timer <= timer - TW'(1);
        GAP: if (timer == '0) begin
          idx          <= idx_next;
          state        <= idx_next == len ? DONE : FETCH;
          blinker_done <= idx_next == len;
        end else timer <= timer - TW'(1);
        // An empty sequence enters DONE with the flag low, so it rises one edge later.
        DONE: begin
          blinker_done <= on_blinker;
          state        <= on_blinker ? DONE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
